// File: rtl/dircc_timer_pkg.sv
// Shared definitions for the node timer driver.
// Contents: word addresses of the interval-timer slave, control-register bit
// indices, the driver FSM state type, and a helper that packs a control word.
package dircc_timer_pkg;

    localparam logic [2:0] TMR_ADDR_STATUS = 3'd0;
    localparam logic [2:0] TMR_ADDR_CTRL   = 3'd1;
    localparam logic [2:0] TMR_ADDR_PERL   = 3'd2;
    localparam logic [2:0] TMR_ADDR_PERH   = 3'd3;
    localparam logic [2:0] TMR_ADDR_SNAPL  = 3'd4;
    localparam logic [2:0] TMR_ADDR_SNAPH  = 3'd5;

    localparam int CTRL_BIT_ITO   = 0;
    localparam int CTRL_BIT_CONT  = 1;
    localparam int CTRL_BIT_START = 2;
    localparam int CTRL_BIT_STOP  = 3;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_PL    = 4'd1,
        ST_WR_PH    = 4'd2,
        ST_WR_CTRL  = 4'd3,
        ST_RUN      = 4'd4,
        ST_CLR      = 4'd5,
        ST_STOP     = 4'd6,
        ST_SNAP_W   = 4'd7,
        ST_SNAP_L   = 4'd8,
        ST_SNAP_H   = 4'd9,
        ST_SNAP_OUT = 4'd10
    } timer_drv_state_t;

    // Packs the four control-register bits in the slave's bit order.
    function automatic logic [3:0] ctrl_word(input logic stop, input logic start,
                                             input logic cont, input logic ito);
        logic [3:0] w;
        w                 = 4'b0000;
        w[CTRL_BIT_STOP]  = stop;
        w[CTRL_BIT_START] = start;
        w[CTRL_BIT_CONT]  = cont;
        w[CTRL_BIT_ITO]   = ito;
        return w;
    endfunction

endpackage

// File: rtl/dircc_node_timer_driver.sv
// Avalon-MM master that programs, starts, services and snapshots one
// interval-timer slave on behalf of node hardware.
// Ports:
//   clk, reset_n                 node clock, asynchronous active-low reset
//   cfg_valid/cfg_ready          period/mode command handshake (ready only in IDLE)
//   cfg_period, cfg_continuous   period in clocks (0 treated as 1), periodic/one-shot
//   stop_req, snap_req           one-cycle request pulses (dropped while idle)
//   tick, timeout_count          pulse per serviced timeout, running count
//   snap_valid, snap_data        snapshot result pulse and value
//   busy                         FSM not idle
//   av_*                         Avalon master to the timer s1 port
// Build option: DIRCC_TIMER_DRV_ELAPSED_EN makes snap_data report elapsed
// clocks (latched period minus snapshot) instead of the raw remaining count.
// All outputs are registered: the output values are decoded from the next state.
module dircc_node_timer_driver
    import dircc_timer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_continuous,
    input  logic              stop_req,
    input  logic              snap_req,
    output logic              tick,
    output logic [CNT_W-1:0]  timeout_count,
    output logic              snap_valid,
    output logic [CNT_W-1:0]  snap_data,
    output logic              busy,
    output logic [2:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [DATA_W-1:0] av_writedata,
    input  logic [DATA_W-1:0] av_readdata,
    input  logic              av_irq
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    timer_drv_state_t state_r, state_s;

    logic [CNT_W-1:0]  period_r, period_s;
    logic              cont_r, cont_s;
    logic              pend_stop_r, pend_stop_s;
    logic              pend_snap_r, pend_snap_s;
    logic              accept_s, stop_eff_s, snap_eff_s;
    logic [DATA_W-1:0] snap_lo_r;
    logic [CNT_W-1:0]  snap_raw_r, snap_result_s;
    logic              snap_out_pend_r;

    logic              cfg_ready_r, busy_r, tick_r, snap_valid_r;
    logic [CNT_W-1:0]  count_r, snap_data_r;
    logic [2:0]        av_addr_r, av_addr_s;
    logic              av_cs_r, av_cs_s, av_wn_r, av_wn_s;
    logic [DATA_W-1:0] av_wd_r, av_wd_s;

    assign accept_s   = (state_r == ST_IDLE) && cfg_valid;
    // A request pulse seen in RUN is acted on in the same cycle.
    assign stop_eff_s = pend_stop_r | stop_req;
    assign snap_eff_s = pend_snap_r | snap_req;
    // The first period write happens in the cycle after accept, before period_r updates.
    assign period_s   = accept_s ? ((cfg_period == {CNT_W{1'b0}}) ? CNT_ONE : cfg_period)
                                 : period_r;
    assign cont_s     = accept_s ? cfg_continuous : cont_r;

`ifdef DIRCC_TIMER_DRV_ELAPSED_EN
    assign snap_result_s = period_r - snap_raw_r;
`else
    assign snap_result_s = snap_raw_r;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; RUN priority is interrupt, then stop, then snapshot.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:     state_s = accept_s ? ST_WR_PL : ST_IDLE;
            ST_WR_PL:    state_s = ST_WR_PH;
            ST_WR_PH:    state_s = ST_WR_CTRL;
            ST_WR_CTRL:  state_s = ST_RUN;
            ST_RUN: begin
                if (av_irq) begin
                    state_s = ST_CLR;
                end else if (stop_eff_s) begin
                    state_s = ST_STOP;
                end else if (snap_eff_s) begin
                    state_s = ST_SNAP_W;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_CLR:      state_s = cont_r ? ST_RUN : ST_IDLE;
            ST_STOP:     state_s = ST_IDLE;
            ST_SNAP_W:   state_s = ST_SNAP_L;
            ST_SNAP_L:   state_s = ST_SNAP_H;
            ST_SNAP_H:   state_s = ST_SNAP_OUT;
            ST_SNAP_OUT: state_s = ST_RUN;
            default:     state_s = ST_IDLE;
        endcase
    end

    // Sticky request flags: cleared in/into IDLE and when their sequence starts.
    always_comb begin
        pend_stop_s = stop_eff_s;
        pend_snap_s = snap_eff_s;
        if ((state_r == ST_IDLE) || (state_s == ST_IDLE)) begin
            pend_stop_s = 1'b0;
            pend_snap_s = 1'b0;
        end else if ((state_r == ST_RUN) && (state_s == ST_STOP)) begin
            pend_stop_s = 1'b0;
        end else if ((state_r == ST_RUN) && (state_s == ST_SNAP_W)) begin
            pend_snap_s = 1'b0;
        end else begin
            pend_stop_s = stop_eff_s;
        end
    end

    // FSM output decode of the next bus cycle; the address holds between commands.
    always_comb begin
        av_cs_s   = 1'b0;
        av_wn_s   = 1'b1;
        av_addr_s = av_addr_r;
        av_wd_s   = {DATA_W{1'b0}};
        case (state_s)
            ST_WR_PL: begin
                av_cs_s = 1'b1; av_wn_s = 1'b0; av_addr_s = TMR_ADDR_PERL;
                av_wd_s = period_s[DATA_W-1:0];
            end
            ST_WR_PH: begin
                av_cs_s = 1'b1; av_wn_s = 1'b0; av_addr_s = TMR_ADDR_PERH;
                av_wd_s = period_s[CNT_W-1:DATA_W];
            end
            ST_WR_CTRL: begin
                av_cs_s = 1'b1; av_wn_s = 1'b0; av_addr_s = TMR_ADDR_CTRL;
                av_wd_s = {{(DATA_W-4){1'b0}}, ctrl_word(1'b0, 1'b1, cont_s, 1'b1)};
            end
            ST_CLR: begin
                av_cs_s = 1'b1; av_wn_s = 1'b0; av_addr_s = TMR_ADDR_STATUS;
            end
            ST_STOP: begin
                av_cs_s = 1'b1; av_wn_s = 1'b0; av_addr_s = TMR_ADDR_CTRL;
                av_wd_s = {{(DATA_W-4){1'b0}}, ctrl_word(1'b1, 1'b0, 1'b0, 1'b0)};
            end
            ST_SNAP_W: begin
                av_cs_s = 1'b1; av_wn_s = 1'b0; av_addr_s = TMR_ADDR_SNAPL;
            end
            ST_SNAP_L:  av_addr_s = TMR_ADDR_SNAPL;
            ST_SNAP_H:  av_addr_s = TMR_ADDR_SNAPH;
            default:    av_addr_s = av_addr_r;
        endcase
    end

    // Output, command and snapshot registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_ready_r     <= 1'b1;
            busy_r          <= 1'b0;
            tick_r          <= 1'b0;
            count_r         <= {CNT_W{1'b0}};
            snap_valid_r    <= 1'b0;
            snap_data_r     <= {CNT_W{1'b0}};
            av_addr_r       <= 3'd0;
            av_cs_r         <= 1'b0;
            av_wn_r         <= 1'b1;
            av_wd_r         <= {DATA_W{1'b0}};
            period_r        <= {CNT_W{1'b0}};
            cont_r          <= 1'b0;
            pend_stop_r     <= 1'b0;
            pend_snap_r     <= 1'b0;
            snap_lo_r       <= {DATA_W{1'b0}};
            snap_raw_r      <= {CNT_W{1'b0}};
            snap_out_pend_r <= 1'b0;
        end else begin
            cfg_ready_r     <= (state_s == ST_IDLE);
            busy_r          <= (state_s != ST_IDLE);
            tick_r          <= (state_s == ST_CLR);
            av_addr_r       <= av_addr_s;
            av_cs_r         <= av_cs_s;
            av_wn_r         <= av_wn_s;
            av_wd_r         <= av_wd_s;
            period_r        <= period_s;
            cont_r          <= cont_s;
            pend_stop_r     <= pend_stop_s;
            pend_snap_r     <= pend_snap_s;
            if (accept_s) begin
                count_r <= {CNT_W{1'b0}};
            end else if (state_r == ST_CLR) begin
                count_r <= count_r + CNT_ONE;
            end else begin
                count_r <= count_r;
            end
            // Read data lags the address by one cycle: low half arrives in SNAP_H.
            if (state_r == ST_SNAP_H) begin
                snap_lo_r <= av_readdata;
            end else begin
                snap_lo_r <= snap_lo_r;
            end
            if (state_r == ST_SNAP_OUT) begin
                snap_raw_r <= {av_readdata, snap_lo_r};
            end else begin
                snap_raw_r <= snap_raw_r;
            end
            snap_out_pend_r <= (state_r == ST_SNAP_OUT);
            snap_valid_r    <= snap_out_pend_r;
            if (snap_out_pend_r) begin
                snap_data_r <= snap_result_s;
            end else begin
                snap_data_r <= snap_data_r;
            end
        end
    end

    assign cfg_ready     = cfg_ready_r;
    assign busy          = busy_r;
    assign tick          = tick_r;
    assign timeout_count = count_r;
    assign snap_valid    = snap_valid_r;
    assign snap_data     = snap_data_r;
    assign av_address    = av_addr_r;
    assign av_chipselect = av_cs_r;
    assign av_write_n    = av_wn_r;
    assign av_writedata  = av_wd_r;

endmodule

// File: tb/tb_dircc_node_timer_driver.sv
// Directed bench for dircc_node_timer_driver with a small behavioural model
// of the interval-timer slave (count down to 0, timeout, reload).
module tb_dircc_node_timer_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_valid, cfg_ready, cfg_continuous, stop_req, snap_req;
    logic [31:0] cfg_period, timeout_count, snap_data;
    logic        tick, snap_valid, busy;
    logic [2:0]  av_address;
    logic        av_chipselect, av_write_n, av_irq;
    logic [15:0] av_writedata, av_readdata;

`ifdef DIRCC_TIMER_DRV_ELAPSED_EN
    localparam logic [31:0] EXP_SNAP1 = 32'd60;
    localparam logic [31:0] EXP_SNAP2 = 32'd3;
`else
    localparam logic [31:0] EXP_SNAP1 = 32'd40;
    localparam logic [31:0] EXP_SNAP2 = 32'd97;
`endif

    dircc_node_timer_driver dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_period(cfg_period),
        .cfg_continuous(cfg_continuous), .stop_req(stop_req), .snap_req(snap_req),
        .tick(tick), .timeout_count(timeout_count), .snap_valid(snap_valid),
        .snap_data(snap_data), .busy(busy), .av_address(av_address),
        .av_chipselect(av_chipselect), .av_write_n(av_write_n),
        .av_writedata(av_writedata), .av_readdata(av_readdata), .av_irq(av_irq)
    );

    always #5 clk = ~clk;

    // ---------------- timer slave model ----------------
    logic [31:0] t_period, t_cnt, t_snap;
    logic        t_run, t_cont, t_ito, t_to;
    logic        force_to, irq_force;

    assign av_irq = (t_to & t_ito) | irq_force;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_period <= 32'd0; t_cnt <= 32'd0; t_snap <= 32'd0;
            t_run <= 1'b0; t_cont <= 1'b0; t_ito <= 1'b0; t_to <= 1'b0;
            av_readdata <= 16'd0;
        end else begin
            if (t_run) begin
                if (t_cnt == 32'd0) begin
                    t_to <= 1'b1; t_cnt <= t_period; t_run <= t_cont;
                end else begin
                    t_cnt <= t_cnt - 32'd1;
                end
            end
            if (force_to) t_to <= 1'b1;
            if (av_chipselect && !av_write_n) begin
                case (av_address)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito <= av_writedata[0]; t_cont <= av_writedata[1];
                        if (av_writedata[2]) t_run <= 1'b1;
                        if (av_writedata[3]) t_run <= 1'b0;
                    end
                    3'd2: begin
                        t_period[15:0] <= av_writedata;
                        t_cnt <= {t_period[31:16], av_writedata};
                    end
                    3'd3: begin
                        t_period[31:16] <= av_writedata;
                        t_cnt <= {av_writedata, t_period[15:0]};
                    end
                    3'd4: t_snap <= t_cnt;
                    default: ;
                endcase
            end
            case (av_address)
                3'd4:    av_readdata <= t_snap[15:0];
                3'd5:    av_readdata <= t_snap[31:16];
                default: av_readdata <= 16'd0;
            endcase
        end
    end

    // ---------------- monitors ----------------
    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
        logic [31:0] cyc;
    } wr_t;

    logic [31:0] cyc = 32'd0;
    wr_t         wr_q[$];
    int          tick_n = 0, snap_n = 0;
    logic [31:0] tick_cyc = 32'd0, snap_cyc = 32'd0, snap_val = 32'd0;

    always @(posedge clk) cyc <= cyc + 32'd1;

    always @(negedge clk) begin
        if (av_chipselect && !av_write_n) wr_q.push_back({av_address, av_writedata, cyc});
        if (tick) begin tick_n++; tick_cyc = cyc; end
        if (snap_valid) begin snap_n++; snap_cyc = cyc; snap_val = snap_data; end
    end

    int vecs = 0;
    int errs = 0;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input logic [31:0] period, input logic cont, output logic [31:0] a);
        int budget = 0;
        while (!cfg_ready && budget < 50) begin step(); budget++; end
        cfg_valid = 1'b1; cfg_period = period; cfg_continuous = cont;
        a = cyc;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if ({cfg_ready, busy, av_chipselect, av_write_n, tick, snap_valid} !== 6'b100100) begin
            errs++;
            $display("FAIL reset_ctrl got %b want 100100",
                     {cfg_ready, busy, av_chipselect, av_write_n, tick, snap_valid});
        end
        vecs++;
        if ({av_address, av_writedata} !== 19'd0) begin
            errs++; $display("FAIL reset_bus got %h want 0", {av_address, av_writedata});
        end
        vecs++;
        if ({timeout_count, snap_data} !== 64'd0) begin
            errs++; $display("FAIL reset_data got %h want 0", {timeout_count, snap_data});
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_continuous();
        logic [31:0] a;
        int base, t0, budget, n_stat;
        wr_t exp [3];
        base = wr_q.size(); t0 = tick_n;
        send_cmd(32'd100, 1'b1, a);
        vecs++;
        if (busy !== 1'b1) begin errs++; $display("FAIL cont_busy got %b want 1", busy); end
        step(); step(); step();
        exp[0] = {3'd2, 16'h0064, a + 32'd1};
        exp[1] = {3'd3, 16'h0000, a + 32'd2};
        exp[2] = {3'd1, 16'h0007, a + 32'd3};
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (wr_q.size() <= base + i || wr_q[base + i] !== exp[i]) begin
                errs++;
                $display("FAIL cont_cfg_wr%0d got %h want %h", i,
                         (wr_q.size() > base + i) ? wr_q[base + i] : '0, exp[i]);
            end
        end
        budget = 0;
        while (tick_n - t0 < 3 && budget < 1000) begin step(); budget++; end
        vecs++;
        if (tick_n - t0 != 3) begin errs++; $display("FAIL cont_ticks got %0d want 3", tick_n - t0); end
        step(); step();
        vecs++;
        if (timeout_count !== 32'd3) begin
            errs++; $display("FAIL cont_count got %0d want 3", timeout_count);
        end
        n_stat = 0;
        for (int i = base; i < wr_q.size(); i++)
            if (wr_q[i].addr == 3'd0 && wr_q[i].data == 16'd0) n_stat++;
        vecs++;
        if (n_stat != 3 || wr_q.size() - base != 6) begin
            errs++; $display("FAIL cont_status_wr got %0d/%0d want 3/6", n_stat, wr_q.size() - base);
        end
    endtask

    task automatic test_snapshot();
        logic [31:0] r;
        int base, s0, budget;
        budget = 0;
        while (t_cnt != 32'd41 && budget < 300) begin step(); budget++; end
        base = wr_q.size(); s0 = snap_n; r = cyc;
        snap_req = 1'b1; step(); snap_req = 1'b0;
        budget = 0;
        while (snap_n == s0 && budget < 20) begin step(); budget++; end
        vecs++;
        if (snap_n == s0) begin errs++; $display("FAIL snap_timeout got none want snap_valid"); end
        vecs++;
        if (wr_q.size() <= base || wr_q[base] !== {3'd4, 16'h0000, r + 32'd1}) begin
            errs++; $display("FAIL snap_write got %h want %h",
                             (wr_q.size() > base) ? wr_q[base] : '0, {3'd4, 16'h0000, r + 32'd1});
        end
        vecs++;
        if (snap_cyc !== r + 32'd6) begin
            errs++; $display("FAIL snap_latency got %0d want %0d", snap_cyc, r + 32'd6);
        end
        vecs++;
        if (snap_val !== EXP_SNAP1) begin
            errs++; $display("FAIL snap_value got %0d want %0d", snap_val, EXP_SNAP1);
        end
    endtask

    task automatic test_irq_and_snap();
        logic [31:0] r;
        int t0, s0, budget;
        budget = 0;
        while (av_irq !== 1'b1 && budget < 300) begin step(); budget++; end
        t0 = tick_n; s0 = snap_n; r = cyc;
        snap_req = 1'b1; step(); snap_req = 1'b0;
        budget = 0;
        while (snap_n == s0 && budget < 30) begin step(); budget++; end
        vecs++;
        if (tick_n - t0 != 1 || tick_cyc !== r + 32'd1) begin
            errs++; $display("FAIL both_tick got n=%0d cyc=%0d want n=1 cyc=%0d",
                             tick_n - t0, tick_cyc, r + 32'd1);
        end
        vecs++;
        if (snap_n - s0 != 1 || snap_cyc !== r + 32'd8) begin
            errs++; $display("FAIL both_snap got n=%0d cyc=%0d want n=1 cyc=%0d",
                             snap_n - s0, snap_cyc, r + 32'd8);
        end
        vecs++;
        if (snap_val !== EXP_SNAP2) begin
            errs++; $display("FAIL both_snap_value got %0d want %0d", snap_val, EXP_SNAP2);
        end
    endtask

    task automatic test_stop();
        logic [31:0] r;
        int base, t0;
        base = wr_q.size(); r = cyc;
        stop_req = 1'b1; step(); stop_req = 1'b0;
        step(); step();
        vecs++;
        if (wr_q.size() - base != 1 || wr_q[base] !== {3'd1, 16'h0008, r + 32'd1}) begin
            errs++; $display("FAIL stop_write got n=%0d %h want n=1 %h", wr_q.size() - base,
                             (wr_q.size() > base) ? wr_q[base] : '0, {3'd1, 16'h0008, r + 32'd1});
        end
        vecs++;
        if ({busy, cfg_ready} !== 2'b01) begin
            errs++; $display("FAIL stop_idle got busy/ready=%b want 01", {busy, cfg_ready});
        end
        t0 = tick_n;
        repeat (2) begin
            irq_force = 1'b1; step(); step();
            irq_force = 1'b0; step(); step();
        end
        repeat (5) step();
        vecs++;
        if (tick_n != t0) begin errs++; $display("FAIL stop_no_tick got %0d want 0", tick_n - t0); end
        base = wr_q.size();
        stop_req = 1'b1; step(); stop_req = 1'b0;
        repeat (8) step();
        vecs++;
        if (wr_q.size() != base || busy !== 1'b0) begin
            errs++; $display("FAIL idle_stop got writes=%0d busy=%b want 0 0", wr_q.size() - base, busy);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] a;
        int base, t0, budget;
        wr_t exp [3];
        base = wr_q.size();
        send_cmd(32'h0001_0000, 1'b0, a);
        step(); step(); step();
        exp[0] = {3'd2, 16'h0000, a + 32'd1};
        exp[1] = {3'd3, 16'h0001, a + 32'd2};
        exp[2] = {3'd1, 16'h0005, a + 32'd3};
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (wr_q.size() <= base + i || wr_q[base + i] !== exp[i]) begin
                errs++;
                $display("FAIL oneshot_cfg_wr%0d got %h want %h", i,
                         (wr_q.size() > base + i) ? wr_q[base + i] : '0, exp[i]);
            end
        end
        t0 = tick_n;
        force_to = 1'b1; step(); force_to = 1'b0;
        budget = 0;
        while (tick_n == t0 && budget < 20) begin step(); budget++; end
        step(); step(); step();
        vecs++;
        if (tick_n - t0 != 1) begin errs++; $display("FAIL oneshot_tick got %0d want 1", tick_n - t0); end
        vecs++;
        if ({busy, cfg_ready} !== 2'b01) begin
            errs++; $display("FAIL oneshot_idle got busy/ready=%b want 01", {busy, cfg_ready});
        end
        vecs++;
        if (wr_q.size() - base != 4 || timeout_count !== 32'd1) begin
            errs++; $display("FAIL oneshot_clear got writes=%0d count=%0d want 4 1",
                             wr_q.size() - base, timeout_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        int base, s0;
        wr_t exp [3];
        send_cmd(32'd100, 1'b1, a);
        step(); step(); step();
        s0 = snap_n;
        snap_req = 1'b1; step(); snap_req = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        vecs++;
        if ({cfg_ready, busy, av_chipselect, av_write_n, tick, snap_valid} !== 6'b100100 ||
            {av_address, av_writedata, timeout_count, snap_data} !== 83'd0) begin
            errs++; $display("FAIL midreset_outputs got %b %h want 100100 0",
                             {cfg_ready, busy, av_chipselect, av_write_n, tick, snap_valid},
                             {av_address, av_writedata, timeout_count, snap_data});
        end
        step(); step();
        reset_n = 1'b1;
        repeat (10) step();
        vecs++;
        if (snap_n != s0) begin errs++; $display("FAIL midreset_snap got %0d want 0", snap_n - s0); end
        base = wr_q.size();
        send_cmd(32'd50, 1'b0, a);
        step(); step(); step();
        exp[0] = {3'd2, 16'h0032, a + 32'd1};
        exp[1] = {3'd3, 16'h0000, a + 32'd2};
        exp[2] = {3'd1, 16'h0005, a + 32'd3};
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (wr_q.size() <= base + i || wr_q[base + i] !== exp[i]) begin
                errs++;
                $display("FAIL midreset_cfg_wr%0d got %h want %h", i,
                         (wr_q.size() > base + i) ? wr_q[base + i] : '0, exp[i]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; cfg_valid = 1'b0; cfg_period = 32'd0; cfg_continuous = 1'b0;
        stop_req = 1'b0; snap_req = 1'b0; force_to = 1'b0; irq_force = 1'b0;
        test_reset();
        test_continuous();
        test_snapshot();
        test_irq_and_snap();
        test_stop();
        test_oneshot();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
